// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline-control definitions for the ARM PPU:
// forwarding select codes, controller state encodings and the PC register number.
package ppu_defs;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } ppu_state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority forwarding selector for one ID-stage operand (EX > MEM > WB > RF).
// Ports: src/use_src = operand register and its use flag; *_rd/*_en = producer stages; sel = mux code.
module fwd_select
    import ppu_defs::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  logic [3:0] ex_rd,
    input  logic       ex_en,
    input  logic [3:0] mem_rd,
    input  logic       mem_en,
    input  logic [3:0] wb_rd,
    input  logic       wb_en,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        // PC reads come from the PC path, never from a forwarded result
        if (use_src && (src != REG_PC)) begin
            if (ex_en && (ex_rd == src)) begin
                sel = FWD_EX;
            end else if (mem_en && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_en && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline controller: load-use stall FSM, branch flush, operand forwarding, event counters.
// Ports: ID sources/use flags, EX/MEM/WB destinations, branch_taken in; LE/flush/NOP/FWD selects, counters out.
module hazard_forward_unit
    import ppu_defs::*;
#(
    parameter int LOAD_PENALTY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic [3:0]       EX_RD,
    input  logic             EX_RF_enable,
    input  logic             EX_load_instr,
    input  logic [3:0]       MEM_RD,
    input  logic             MEM_RF_enable,
    input  logic [3:0]       WB_RD,
    input  logic             WB_RF_enable,
    input  logic             branch_taken,
    output logic             PC_LE,
    output logic             IFID_LE,
    output logic             IFID_Clr,
    output logic             CU_MUX_E,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       FWD_D,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Extra bubbles spent in LSTALL after the first one issued from RUN
    localparam logic [1:0] PEN_INIT =
        2'((LOAD_PENALTY > 1) ? (LOAD_PENALTY - 2) : 0);

    ppu_state_t       state_q, state_d;
    logic [1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] fwd_a_raw, fwd_b_raw, fwd_d_raw;
    logic       hit_n, hit_m, hit_d, hazard;
    logic       stall, flush;

    fwd_select u_fwd_a (
        .src(ID_Rn), .use_src(ID_use_Rn),
        .ex_rd(EX_RD), .ex_en(EX_RF_enable),
        .mem_rd(MEM_RD), .mem_en(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_en(WB_RF_enable),
        .sel(fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .src(ID_Rm), .use_src(ID_use_Rm),
        .ex_rd(EX_RD), .ex_en(EX_RF_enable),
        .mem_rd(MEM_RD), .mem_en(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_en(WB_RF_enable),
        .sel(fwd_b_raw)
    );

    fwd_select u_fwd_d (
        .src(ID_Rd), .use_src(ID_use_Rd),
        .ex_rd(EX_RD), .ex_en(EX_RF_enable),
        .mem_rd(MEM_RD), .mem_en(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_en(WB_RF_enable),
        .sel(fwd_d_raw)
    );

    assign hit_n  = ID_use_Rn && (ID_Rn != REG_PC) && (ID_Rn == EX_RD);
    assign hit_m  = ID_use_Rm && (ID_Rm != REG_PC) && (ID_Rm == EX_RD);
    assign hit_d  = ID_use_Rd && (ID_Rd != REG_PC) && (ID_Rd == EX_RD);
    assign hazard = EX_load_instr && EX_RF_enable && (hit_n || hit_m || hit_d);

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        stall       = 1'b0;
        flush       = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            RUN: begin
                if (hazard) begin
                    // Stall beats a simultaneous branch; the branch is seen again afterwards
                    stall = 1'b1;
                    if (LOAD_PENALTY > 1) begin
                        state_d = LSTALL;
                        pcnt_d  = PEN_INIT;
                    end
                end else if (branch_taken) begin
                    flush = 1'b1;
                end
            end
            LSTALL: begin
                stall = 1'b1;
                if (pcnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    pcnt_d = pcnt_q - 2'd1;
                end
            end
        endcase

        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q     <= RUN;
            pcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While Clr is held, all controls sit at their idle values regardless of inputs
    assign PC_LE       = Clr || !stall;
    assign IFID_LE     = Clr || !stall;
    assign CU_MUX_E    = !Clr && stall;
    assign IFID_Clr    = !Clr && flush;
    assign FWD_A       = Clr ? FWD_RF : fwd_a_raw;
    assign FWD_B       = Clr ? FWD_RF : fwd_b_raw;
    assign FWD_D       = Clr ? FWD_RF : fwd_d_raw;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
